// File: rtl/char_buf_pkg.sv
// Shared constants and reader state type for the character screen buffer
// (11 rows x 64 columns of 8-bit ASCII, row-major).
package char_buf_pkg;

    localparam int CHAR_COLS    = 64;
    localparam int CHAR_ROWS    = 11;
    localparam int CHAR_W       = 8;
    localparam int CHAR_BUF_LEN = CHAR_COLS * CHAR_ROWS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } rd_state_e;

endpackage

// File: rtl/char_buffer_reader_if.sv
// Character stream from the buffer reader to the glyph renderer / display driver.
interface char_buffer_reader_if
    import char_buf_pkg::*;
#(
    parameter int CW = CHAR_W
);
    logic [CW-1:0] char_out;
    logic [3:0]    row;
    logic [5:0]    col;
    logic          valid;
    logic          ready;
    logic          last;

    modport master (output char_out, row, col, valid, last, input ready);
    modport slave  (input char_out, row, col, valid, last, output ready);
endinterface

// File: rtl/char_pos_counter.sv
// Row/column position counter for the buffer walk; col wraps into the next row,
// row wraps after the final row.
module char_pos_counter #(
    parameter int COLS = 64,
    parameter int ROWS = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       adv_i,
    output logic [3:0] row_o,
    output logic [5:0] col_o,
    output logic       last_o
);

    logic [3:0] row_q, row_d;
    logic [5:0] col_q, col_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (col_q == 6'(COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == 4'(ROWS - 1)) ? '0 : row_q + 4'd1;
            end else begin
                col_d = col_q + 6'd1;
            end
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == 4'(ROWS - 1)) && (col_q == 6'(COLS - 1));

endmodule

// File: rtl/char_buffer_reader.sv
// Row-major reader of the character screen buffer, one character per handshake.
// Define CHAR_BUFFER_READER_LOOP_EN to rescan frames continuously after the first start.
module char_buffer_reader
    import char_buf_pkg::*;
#(
    parameter int COLS = CHAR_COLS,
    parameter int ROWS = CHAR_ROWS,
    parameter int CW   = CHAR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] data [ROWS*COLS-1:0],
    input  logic          start,
    output logic          busy,
    output logic          done,
    char_buffer_reader_if.master rd
);

    localparam int AW = $clog2(ROWS * COLS);

    rd_state_e     state_q, state_d;
    logic [CW-1:0] char_q, char_d;
    logic [3:0]    row_q, row_d;
    logic [5:0]    col_q, col_d;

    logic          cnt_clr, cnt_adv;
    logic [3:0]    pos_row;
    logic [5:0]    pos_col;
    logic          pos_last;
    logic [AW-1:0] addr;

    char_pos_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_pos (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr),
        .adv_i  (cnt_adv),
        .row_o  (pos_row),
        .col_o  (pos_col),
        .last_o (pos_last)
    );

    // Column 0 sits at the high end of each row's slice.
    assign addr = AW'(pos_row) * AW'(COLS) + AW'(COLS - 1) - AW'(pos_col);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            char_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                char_d  = data[addr];
                row_d   = pos_row;
                col_d   = pos_col;
                state_d = SEND;
            end
            SEND: begin
                // The counter is only advanced on acceptance, so it still names the held character.
                if (rd.ready) begin
                    if (pos_last) begin
                        state_d = DONE;
                    end else begin
                        cnt_adv = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
`ifdef CHAR_BUFFER_READER_LOOP_EN
                cnt_clr = 1'b1;
                state_d = LOAD;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd.char_out = char_q;
    assign rd.row      = row_q;
    assign rd.col      = col_q;
    assign rd.valid    = (state_q == SEND);
    assign rd.last     = rd.valid && (row_q == 4'(ROWS - 1)) && (col_q == 6'(COLS - 1));
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule
